spi_reg_dcd_burst: RTL

- Parametrised successor of the single-byte SPI instruction decoder.
- Decodes the byte stream from the SPI slave into register-bus read/write pulses.
- Supports multi-byte register words and an auto-increment burst mode that runs until frame end.
- Sits between the SPI slave interface and the register file of the PWM generator.

---
 rtl/spi_reg_dcd_burst.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/spi_reg_dcd_burst.sv
// SPI byte-stream to register-bus decoder with multi-byte words and auto-increment bursts.
// Command byte: [7]=write, [6]=burst, [ADDR_W-1:0]=start address.
module spi_reg_dcd_burst #(
    parameter int ADDR_W     = 6,
    parameter int DATA_BYTES = 2,
    parameter int MIN_GAP    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_sync,
    input  logic                    frame_end,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    output logic                    read,
    output logic                    write,
    output logic [ADDR_W-1:0]       addr,
    input  logic [8*DATA_BYTES-1:0] data_read,
    output logic [8*DATA_BYTES-1:0] data_write,
    output logic                    busy
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);

    // A read fetch occupies the two cycles after a byte, so bytes must be at least 3 cycles apart.
    if (ADDR_W < 1 || ADDR_W > 6 || DATA_BYTES < 1 || DATA_BYTES > 4 || MIN_GAP < 3) begin : g_bad_param
        $error("spi_reg_dcd_burst: unsupported parameter set");
    end

    typedef enum logic [1:0] {S_CMD, S_RFETCH, S_RDATA, S_WDATA} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              burst, burst_n;
    logic [DW-1:0]     rbuf, rbuf_n, wbuf, wbuf_n;
    logic [DW-1:0]     rbuf_sh, wword;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        data_out_n;
    logic [DW-1:0]     data_write_n;
    logic              read_n, write_n, last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CMD;
            cnt        <= '0;
            burst      <= 1'b0;
            rbuf       <= '0;
            wbuf       <= '0;
            addr       <= '0;
            data_out   <= '0;
            data_write <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            burst      <= burst_n;
            rbuf       <= rbuf_n;
            wbuf       <= wbuf_n;
            addr       <= addr_n;
            data_out   <= data_out_n;
            data_write <= data_write_n;
            read       <= read_n;
            write      <= write_n;
            busy       <= (state_n != S_CMD);
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        burst_n      = burst;
        rbuf_n       = rbuf;
        wbuf_n       = wbuf;
        addr_n       = addr;
        data_out_n   = data_out;
        data_write_n = data_write;
        read_n       = 1'b0;
        write_n      = 1'b0;
        last         = (cnt == LAST);
        rbuf_sh      = rbuf << 8;
        wword        = (wbuf << 8) | DW'(data_in);

        // Burst writes advance the address once the strobe has been seen at the old address.
        if (write && burst && !frame_end)
            addr_n = addr + ADDR_W'(1);

        if (frame_end) begin
            state_n = S_CMD;
            cnt_n   = '0;
            wbuf_n  = '0;
        end else begin
            case (state)
                S_CMD: if (byte_sync) begin
                    burst_n = data_in[6];
                    addr_n  = data_in[ADDR_W-1:0];
                    cnt_n   = '0;
                    wbuf_n  = '0;
                    if (data_in[7]) begin
                        state_n = S_WDATA;
                    end else begin
                        state_n = S_RFETCH;
                        read_n  = 1'b1;
                    end
                end
                // First cycle here carries the read strobe; data_read is valid on the second.
                S_RFETCH: if (!read) begin
                    rbuf_n     = data_read;
                    data_out_n = data_read[DW-1 -: 8];
                    state_n    = S_RDATA;
                end
                S_RDATA: if (byte_sync) begin
                    if (last) begin
                        cnt_n = '0;
                        if (burst) begin
                            addr_n  = addr + ADDR_W'(1);
                            read_n  = 1'b1;
                            state_n = S_RFETCH;
                        end else begin
                            state_n = S_CMD;
                        end
                    end else begin
                        cnt_n      = cnt + CW'(1);
                        rbuf_n     = rbuf_sh;
                        data_out_n = rbuf_sh[DW-1 -: 8];
                    end
                end
                S_WDATA: if (byte_sync) begin
                    if (last) begin
                        cnt_n        = '0;
                        wbuf_n       = '0;
                        data_write_n = wword;
                        write_n      = 1'b1;
                        state_n      = burst ? S_WDATA : S_CMD;
                    end else begin
                        cnt_n  = cnt + CW'(1);
                        wbuf_n = wword;
                    end
                end
                default: state_n = S_CMD;
            endcase
        end
    end
endmodule
